// File: rtl/rr_grant_ctrl.sv
// Output-port grant controller: locks the encoder's winner for one wormhole packet, gates flits on credits.
// Optional idle-lock timeout with timeout_o port: define RR_GRANT_TIMEOUT_EN.
module rr_grant_ctrl #(
    parameter  int CREDITS = 4,
    parameter  int TIMEOUT = 64,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    req_i,
    input  logic [2:0]    sel_i,
    input  logic [4:0]    flit_valid_i,
    input  logic [4:0]    tail_i,
    input  logic          credit_i,
    output logic [4:0]    grant_o,
    output logic [4:0]    pop_o,
    output logic [2:0]    xbar_sel_o,
    output logic          xbar_valid_o,
    output logic          rr_change_order_o,
`ifdef RR_GRANT_TIMEOUT_EN
    output logic          timeout_o,
`endif
    output logic [CW-1:0] credit_cnt_o
);

    typedef enum logic [1:0] {IDLE, LOCK, RELEASE} state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    state_t        state, next_state;
    logic [2:0]    sel_q;
    logic [CW-1:0] credit_cnt;
    logic          xfer;
    logic [4:0]    req_sel_oh;
    logic [4:0]    lock_oh;

    // Port N sits at bit 4, so select s maps to bit 4-s; selects above 4 shift out to zero.
    assign req_sel_oh = 5'b10000 >> sel_i;
    assign lock_oh    = 5'b10000 >> sel_q;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
    logic          timeout_hit;
    logic          timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if (state == LOCK && !xfer) idle_cnt <= idle_cnt + 1'b1;
            else                        idle_cnt <= '0;
        end
    end

    assign timeout_o = timeout_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= 3'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == LOCK) sel_q <= sel_i;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state        = state;
        grant_o           = 5'b0;
        pop_o             = 5'b0;
        xbar_sel_o        = 3'd0;
        xbar_valid_o      = 1'b0;
        rr_change_order_o = 1'b0;
        xfer              = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
        timeout_hit       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|(req_i & req_sel_oh)) next_state = LOCK;
            end
            LOCK: begin
                grant_o      = lock_oh;
                xbar_sel_o   = sel_q;
                xfer         = (|(flit_valid_i & lock_oh)) && (credit_cnt != '0);
                xbar_valid_o = xfer;
                pop_o        = lock_oh & {5{xfer}};
                if (xfer && |(tail_i & lock_oh)) begin
                    next_state = RELEASE;
                end
`ifdef RR_GRANT_TIMEOUT_EN
                else if (!xfer && idle_cnt == IW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    next_state  = RELEASE;
                end
`endif
            end
            RELEASE: begin
                rr_change_order_o = 1'b1;
                next_state        = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A credit return and a transfer in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CRED_MAX;
        end else if (xfer && !credit_i) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (credit_i && !xfer && credit_cnt != CRED_MAX) begin
            credit_cnt <= credit_cnt + 1'b1;
        end
    end

    assign credit_cnt_o = credit_cnt;

endmodule
